// File: rtl/oven_pkg.sv
// Shared definitions for the oven countdown timer: controller states,
// BCD limits, the digit width seen by the seven-segment decoders, and
// BCD <-> binary helpers used by the add/saturate path.
package oven_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } oven_state_t;

  // BCD digit limits: ones digits roll at 9, seconds-tens at 5
  localparam digit_t     BCD_ONES_MAX = 4'd9;
  localparam digit_t     BCD_TENS_MAX = 4'd5;
  localparam logic [6:0] MIN_MAX      = 7'd99;
  localparam logic [6:0] SEC_PER_MIN  = 7'd60;
  localparam logic [6:0] SEC_STEP     = 7'd10;

  typedef struct packed {
    digit_t min_tens;
    digit_t min_ones;
    digit_t sec_tens;
    digit_t sec_ones;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = '0;
  localparam bcd_time_t TIME_SAT  = '{min_tens: 4'd9, min_ones: 4'd9,
                                      sec_tens: BCD_TENS_MAX, sec_ones: BCD_ONES_MAX};

  // Two BCD digits (00..99) to binary
  function automatic logic [6:0] bcd2bin(input digit_t tens, input digit_t ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  // Binary 0..99 to two BCD digits {tens, ones}
  function automatic logic [2*DIGIT_W-1:0] bin2bcd(input logic [6:0] v);
    logic [6:0] t;
    logic [6:0] o;
    t = v / 7'd10;
    o = v - t * 7'd10;
    return {DIGIT_W'(t), DIGIT_W'(o)};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..CLK_HZ-1 while enabled and fires o_tick in the
// cycle the count sits at CLK_HZ-1, wrapping back to 0. Holding i_en low
// freezes the count (fraction of a period is kept); i_clr zeroes it.
module tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned        CNT_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && !i_clr && (r_cnt == CNT_LAST);

  // Period counter with clear priority over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oven_countdown.sv
// Oven cook-time countdown: MM:SS in BCD, loaded by button pulses,
// decremented once per second in RUN, driving heater_on and a done pulse.
// Optional: define OVEN_BEEP_EN to add the beep output, which stays high
// for BEEP_SEC seconds after reaching 00:00 (cut short by leaving DONE).
module oven_countdown
  import oven_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000
`ifdef OVEN_BEEP_EN
 ,parameter int unsigned BEEP_SEC = 3
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_min,
  input  logic               btn_sec,
  input  logic               btn_start,
  input  logic               btn_stop,
  input  logic               btn_clear,
  input  logic               door_open,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               heater_on,
  output logic               done
`ifdef OVEN_BEEP_EN
 ,output logic               beep
`endif
);

  oven_state_t r_state;
  bcd_time_t   r_time;
  logic        r_heater;
  logic        r_done;

  bcd_time_t   w_time_add;
  bcd_time_t   w_time_dec;
  logic [6:0]  w_min_bin;
  logic [6:0]  w_sec_bin;
  logic        w_zero;
  logic        w_dec_zero;
  logic        w_can_start;
  logic        w_run_stay;
  logic        w_presc_en;
  logic        w_presc_clr;
  logic        w_sec_tick;

  assign w_zero      = (r_time == TIME_ZERO);
  assign w_dec_zero  = (w_time_dec == TIME_ZERO);
  assign w_can_start = btn_start && !door_open && !w_zero;
  // RUN and not being pulled out of it this cycle; only then does time advance
  assign w_run_stay  = (r_state == ST_RUN) && !btn_clear && !door_open && !btn_stop;
  assign w_presc_clr = (r_state == ST_IDLE) && !btn_clear && w_can_start;

  // Add path: done in binary so the seconds carry and the 99:59 clamp are simple
  always_comb begin
    w_min_bin = bcd2bin(r_time.min_tens, r_time.min_ones);
    w_sec_bin = bcd2bin(r_time.sec_tens, r_time.sec_ones);
    if (btn_min && (w_min_bin != MIN_MAX)) begin
      w_min_bin = w_min_bin + 7'd1;
    end
    if (btn_sec) begin
      w_sec_bin = w_sec_bin + SEC_STEP;
      if (w_sec_bin >= SEC_PER_MIN) begin
        w_sec_bin = w_sec_bin - SEC_PER_MIN;
        w_min_bin = w_min_bin + 7'd1;
      end
    end
    if (w_min_bin > MIN_MAX) begin
      w_time_add = TIME_SAT;
    end else begin
      w_time_add = {bin2bcd(w_min_bin), bin2bcd(w_sec_bin)};
    end
  end

  // One-second decrement with a BCD borrow chain
  always_comb begin
    w_time_dec = r_time;
    if (r_time.sec_ones != '0) begin
      w_time_dec.sec_ones = r_time.sec_ones - 4'd1;
    end else begin
      w_time_dec.sec_ones = BCD_ONES_MAX;
      if (r_time.sec_tens != '0) begin
        w_time_dec.sec_tens = r_time.sec_tens - 4'd1;
      end else begin
        w_time_dec.sec_tens = BCD_TENS_MAX;
        if (r_time.min_ones != '0) begin
          w_time_dec.min_ones = r_time.min_ones - 4'd1;
        end else begin
          w_time_dec.min_ones = BCD_ONES_MAX;
          w_time_dec.min_tens = r_time.min_tens - 4'd1;
        end
      end
    end
  end

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_presc_en),
    .i_clr (w_presc_clr),
    .o_tick(w_sec_tick)
  );

  // Controller FSM with registered digits, heater enable and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_time   <= TIME_ZERO;
      r_heater <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (btn_clear) begin
        r_state  <= ST_IDLE;
        r_time   <= TIME_ZERO;
        r_heater <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_PAUSE: begin
            if (w_can_start) begin
              r_state  <= ST_RUN;
              r_heater <= 1'b1;
            end else begin
              r_time <= w_time_add;
            end
          end
          ST_RUN: begin
            if (door_open || btn_stop) begin
              r_state  <= ST_PAUSE;
              r_heater <= 1'b0;
            end else if (w_sec_tick) begin
              r_time <= w_time_dec;
              if (w_dec_zero) begin
                r_state  <= ST_DONE;
                r_heater <= 1'b0;
                r_done   <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (btn_start || btn_min || btn_sec) begin
              r_state <= ST_IDLE;
              r_time  <= w_time_add;
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_heater <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef OVEN_BEEP_EN
  logic r_beep;
  logic w_beep_tick;
  logic w_enter_done;
  logic w_done_exit;

  assign w_enter_done = (r_state == ST_RUN) && w_sec_tick && w_dec_zero;
  assign w_done_exit  = (r_state == ST_DONE) && (btn_clear || btn_start || btn_min || btn_sec);
  // Prescaler keeps running in DONE only while the beep is timing out
  assign w_presc_en   = w_run_stay || ((r_state == ST_DONE) && r_beep);

  tick_gen #(
    .CLK_HZ(BEEP_SEC)
  ) u_beep_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_sec_tick && (r_state == ST_DONE)),
    .i_clr (w_enter_done),
    .o_tick(w_beep_tick)
  );

  // Beep from DONE entry until BEEP_SEC seconds elapse or DONE is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beep <= 1'b0;
    end else if (w_enter_done) begin
      r_beep <= 1'b1;
    end else if (w_done_exit || w_beep_tick) begin
      r_beep <= 1'b0;
    end
  end

  assign beep = r_beep;
`else
  assign w_presc_en = w_run_stay;
`endif

  assign min_tens  = r_time.min_tens;
  assign min_ones  = r_time.min_ones;
  assign sec_tens  = r_time.sec_tens;
  assign sec_ones  = r_time.sec_ones;
  assign heater_on = r_heater;
  assign done      = r_done;

endmodule

// File: tb/tb_oven_countdown.sv
// Bench for oven_countdown with CLK_HZ = 4 (BEEP_SEC = 3 when OVEN_BEEP_EN).
// Directed scenarios check fixed expected values; a randomized run compares
// against a seconds-based behavioural model of the timer.
`timescale 1ns/1ps
module tb_oven_countdown;

  localparam int unsigned HZ     = 4;
  localparam int unsigned BEEP_S = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_min = 1'b0, btn_sec = 1'b0, btn_start = 1'b0;
  logic       btn_stop = 1'b0, btn_clear = 1'b0, door_open = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       heater_on, done;
`ifdef OVEN_BEEP_EN
  logic       beep;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: minutes/seconds as plain integers
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t m_st = M_IDLE;
  int      m_min = 0, m_sec = 0, m_frac = 0, m_beep_cyc = 0;
  bit      m_done = 1'b0, m_heat = 1'b0;

  always #5 clk = ~clk;

  oven_countdown #(
    .CLK_HZ(HZ)
`ifdef OVEN_BEEP_EN
   ,.BEEP_SEC(BEEP_S)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_min(btn_min), .btn_sec(btn_sec), .btn_start(btn_start),
    .btn_stop(btn_stop), .btn_clear(btn_clear), .door_open(door_open),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .heater_on(heater_on), .done(done)
`ifdef OVEN_BEEP_EN
   ,.beep(beep)
`endif
  );

  function automatic logic [15:0] dut_digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [15:0] m_digits();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  function automatic bit m_beep();
    return (m_st == M_DONE) && (m_beep_cyc < int'(BEEP_S * HZ));
  endfunction

  function automatic void m_add();
    if (btn_min && m_min < 99) m_min++;
    if (btn_sec) begin
      m_sec += 10;
      if (m_sec >= 60) begin
        m_sec -= 60;
        m_min++;
      end
    end
    if (m_min > 99) begin
      m_min = 99;
      m_sec = 59;
    end
  endfunction

  // Advance the model with the current inputs, clock once, drop pulses
  task automatic step();
    mstate_t ns;
    bit      nd;
    int      tot;
    bit      zero;
    ns   = m_st;
    nd   = 1'b0;
    zero = (m_min == 0) && (m_sec == 0);
    if (!rst_n) begin
      ns = M_IDLE; m_min = 0; m_sec = 0; m_frac = 0;
    end else if (btn_clear) begin
      ns = M_IDLE; m_min = 0; m_sec = 0;
    end else begin
      case (m_st)
        M_IDLE, M_PAUSE: begin
          if (btn_start && !door_open && !zero) begin
            ns = M_RUN;
            if (m_st == M_IDLE) m_frac = 0;
          end else begin
            m_add();
          end
        end
        M_RUN: begin
          if (door_open || btn_stop) begin
            ns = M_PAUSE;
          end else if (m_frac == int'(HZ) - 1) begin
            m_frac = 0;
            tot = m_min * 60 + m_sec - 1;
            m_min = tot / 60;
            m_sec = tot % 60;
            if (tot == 0) begin
              ns = M_DONE;
              nd = 1'b1;
            end
          end else begin
            m_frac++;
          end
        end
        M_DONE: begin
          if (btn_start || btn_min || btn_sec) begin
            ns = M_IDLE;
            m_add();
          end
        end
        default: ns = M_IDLE;
      endcase
    end
    if (ns == M_DONE) m_beep_cyc = (m_st == M_DONE) ? m_beep_cyc + 1 : 0;
    m_st   = ns;
    m_done = nd;
    m_heat = (ns == M_RUN);
    @(posedge clk);
    #1;
    btn_min = 1'b0; btn_sec = 1'b0; btn_start = 1'b0;
    btn_stop = 1'b0; btn_clear = 1'b0;
  endtask

  task automatic do_reset();
    door_open = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({dut_digits(), heater_on, done} !== 18'h0) begin
      errors++;
      $display("FAIL reset_initial: got digits=%h heater=%b done=%b, expected 0000/0/0", dut_digits(), heater_on, done);
    end
    do_reset();
    btn_min = 1'b1; step();
    btn_start = 1'b1; step();
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dut_digits(), heater_on, done} !== 18'h0) begin
      errors++;
      $display("FAIL reset_midrun: got digits=%h heater=%b done=%b, expected 0000/0/0", dut_digits(), heater_on, done);
    end
    step();
    rst_n = 1'b1;
    step();
    btn_min = 1'b1; step();
    checks++;
    if ({dut_digits(), heater_on} !== {16'h0100, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle_after: got digits=%h heater=%b, expected 0100/0", dut_digits(), heater_on);
    end
  endtask

  task automatic test_load_run();
    int n;
    bit seen;
    do_reset();
    btn_min = 1'b1; step();
    btn_sec = 1'b1; step();
    checks++;
    if (dut_digits() !== 16'h0110) begin
      errors++; $display("FAIL load_digits: got %h, expected 0110", dut_digits());
    end
    btn_start = 1'b1; step();
    checks++;
    if (heater_on !== 1'b1) begin
      errors++; $display("FAIL start_heater: got %b, expected 1", heater_on);
    end
    repeat (3) step();
    checks++;
    if (dut_digits() !== 16'h0110) begin
      errors++; $display("FAIL pre_tick: got %h, expected 0110", dut_digits());
    end
    step();
    checks++;
    if (dut_digits() !== 16'h0109) begin
      errors++; $display("FAIL first_tick: got %h, expected 0109", dut_digits());
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      step();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 276) begin
      errors++; $display("FAIL done_latency: got seen=%0d after %0d cycles, expected done after 276", seen, n);
    end
    checks++;
    if ({dut_digits(), heater_on} !== {16'h0000, 1'b0}) begin
      errors++; $display("FAIL done_state: got digits=%h heater=%b, expected 0000/0", dut_digits(), heater_on);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got done=%b one cycle later, expected 0", done);
    end
    btn_sec = 1'b1; step();
    checks++;
    if ({dut_digits(), heater_on} !== {16'h0010, 1'b0}) begin
      errors++; $display("FAIL done_exit_add: got digits=%h heater=%b, expected 0010/0", dut_digits(), heater_on);
    end
    btn_start = 1'b1; step();
    checks++;
    if (heater_on !== 1'b1) begin
      errors++; $display("FAIL restart_after_done: got heater=%b, expected 1", heater_on);
    end
  endtask

  task automatic test_borrow();
    do_reset();
    repeat (10) begin btn_min = 1'b1; step(); end
    btn_start = 1'b1; step();
    btn_min = 1'b1; step();
    repeat (2) step();
    checks++;
    if (dut_digits() !== 16'h1000) begin
      errors++; $display("FAIL run_ignores_add: got %h, expected 1000", dut_digits());
    end
    step();
    checks++;
    if (dut_digits() !== 16'h0959) begin
      errors++; $display("FAIL borrow_chain: got %h, expected 0959", dut_digits());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (5) begin btn_sec = 1'b1; step(); end
    checks++;
    if (dut_digits() !== 16'h0050) begin
      errors++; $display("FAIL sec_add: got %h, expected 0050", dut_digits());
    end
    btn_sec = 1'b1; step();
    checks++;
    if (dut_digits() !== 16'h0100) begin
      errors++; $display("FAIL sec_carry: got %h, expected 0100", dut_digits());
    end
    repeat (100) begin btn_min = 1'b1; step(); end
    checks++;
    if (dut_digits() !== 16'h9900) begin
      errors++; $display("FAIL min_clamp: got %h, expected 9900", dut_digits());
    end
    repeat (5) begin btn_sec = 1'b1; step(); end
    checks++;
    if (dut_digits() !== 16'h9950) begin
      errors++; $display("FAIL sec_to_9950: got %h, expected 9950", dut_digits());
    end
    btn_sec = 1'b1; step();
    checks++;
    if (dut_digits() !== 16'h9959) begin
      errors++; $display("FAIL sat_9959: got %h, expected 9959", dut_digits());
    end
    btn_min = 1'b1; step();
    btn_sec = 1'b1; step();
    checks++;
    if (dut_digits() !== 16'h9959) begin
      errors++; $display("FAIL sat_hold: got %h, expected 9959", dut_digits());
    end
  endtask

  task automatic test_door_pause();
    do_reset();
    btn_min = 1'b1; step();
    btn_start = 1'b1; step();
    repeat (2) step();
    door_open = 1'b1; step();
    checks++;
    if ({dut_digits(), heater_on} !== {16'h0100, 1'b0}) begin
      errors++; $display("FAIL door_pause: got digits=%h heater=%b, expected 0100/0", dut_digits(), heater_on);
    end
    btn_start = 1'b1; step();
    checks++;
    if (heater_on !== 1'b0) begin
      errors++; $display("FAIL start_door_open: got heater=%b, expected 0", heater_on);
    end
    door_open = 1'b0;
    step();
    btn_start = 1'b1; step();
    checks++;
    if (heater_on !== 1'b1) begin
      errors++; $display("FAIL resume: got heater=%b, expected 1", heater_on);
    end
    step();
    checks++;
    if (dut_digits() !== 16'h0100) begin
      errors++; $display("FAIL resume_pre_tick: got %h, expected 0100", dut_digits());
    end
    step();
    checks++;
    if (dut_digits() !== 16'h0059) begin
      errors++; $display("FAIL resume_fraction: got %h, expected 0059 two cycles after resume", dut_digits());
    end
  endtask

  task automatic test_priority();
    do_reset();
    btn_min = 1'b1; step();
    btn_start = 1'b1; step();
    btn_stop = 1'b1; step();
    checks++;
    if (heater_on !== 1'b0) begin
      errors++; $display("FAIL stop_pause: got heater=%b, expected 0", heater_on);
    end
    btn_min = 1'b1; step();
    checks++;
    if (dut_digits() !== 16'h0200) begin
      errors++; $display("FAIL pause_add: got %h, expected 0200", dut_digits());
    end
    btn_start = 1'b1; step();
    btn_clear = 1'b1; btn_start = 1'b1; step();
    checks++;
    if ({dut_digits(), heater_on} !== {16'h0000, 1'b0}) begin
      errors++; $display("FAIL clear_over_start: got digits=%h heater=%b, expected 0000/0", dut_digits(), heater_on);
    end
    btn_start = 1'b1; step();
    checks++;
    if (heater_on !== 1'b0) begin
      errors++; $display("FAIL start_at_zero: got heater=%b, expected 0", heater_on);
    end
  endtask

`ifdef OVEN_BEEP_EN
  task automatic test_beep();
    int n;
    int hi;
    do_reset();
    btn_sec = 1'b1; step();
    btn_start = 1'b1; step();
    n = 0;
    while (done !== 1'b1 && n < 80) begin step(); n++; end
    checks++;
    if (done !== 1'b1 || beep !== 1'b1) begin
      errors++; $display("FAIL beep_start: got done=%b beep=%b, expected 1/1", done, beep);
    end
    hi = 1;
    n = 0;
    while (beep === 1'b1 && n < 40) begin step(); n++; if (beep === 1'b1) hi++; end
    checks++;
    if (hi != int'(BEEP_S * HZ)) begin
      errors++; $display("FAIL beep_len: got %0d cycles high, expected %0d", hi, BEEP_S * HZ);
    end
  endtask
`endif

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 39);
      case (r)
        0, 1: btn_start = 1'b1;
        2, 3: btn_sec = 1'b1;
        4:    if ($urandom_range(0, 3) == 0) btn_min = 1'b1;
        5:    btn_stop = 1'b1;
        6:    if ($urandom_range(0, 3) == 0) btn_clear = 1'b1;
        default: ;
      endcase
      if ($urandom_range(0, 79) == 0) door_open = ~door_open;
      step();
      checks++;
      if ({dut_digits(), heater_on, done} !== {m_digits(), m_heat, m_done}) begin
        errors++;
        $display("FAIL random_cycle%0d: got digits=%h heater=%b done=%b, expected %h/%b/%b",
                 i, dut_digits(), heater_on, done, m_digits(), m_heat, m_done);
      end
`ifdef OVEN_BEEP_EN
      checks++;
      if (beep !== m_beep()) begin
        errors++; $display("FAIL random_beep%0d: got %b, expected %b", i, beep, m_beep());
      end
`endif
    end
    door_open = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_borrow();
    test_saturation();
    test_door_pause();
    test_priority();
`ifdef OVEN_BEEP_EN
    test_beep();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
